tri_assembler_fifo: RTL and testbench

Groups the serial projected-vertex stream from `tri_proj` (one x/y/z vertex per handshake) into complete triangles and buffers them in a first-word-fall-through FIFO. It presents one triangle at a time to `rasterizer` through `vert1`/`vert2`/`vert3`/`valid_tri`, with a ready/valid handshake. It also forwards the end-of-object marker in stream order. The block fills the pipeline gap between projection and rasterization and absorbs rate mismatch between them.

---
 rtl/tri_assembler_fifo_if.sv | 34 +++
 rtl/tri_assembler_fifo.sv | 92 +++++++++
 tb/tb_tri_assembler_fifo.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tri_assembler_fifo_if.sv
// rtl/tri_assembler_fifo_if.sv - vertex-in / triangle-out handshake bundle for tri_assembler_fifo
interface tri_assembler_fifo_if #(
    parameter int COORD_W = 9,
    parameter int DEPTH   = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                        valid_in;
    logic [COORD_W-1:0]          x_in;
    logic [COORD_W-1:0]          y_in;
    logic [COORD_W-1:0]          z_in;
    logic                        obj_done_in;
    logic                        ready_out;
    logic [2:0][COORD_W-1:0]     vert1_out;
    logic [2:0][COORD_W-1:0]     vert2_out;
    logic [2:0][COORD_W-1:0]     vert3_out;
    logic                        valid_tri_out;
    logic                        ready_in;
    logic                        obj_done_out;
    logic [CW-1:0]               count_out;
    logic [7:0]                  drop_count_out;

    modport slave (
        input  valid_in, x_in, y_in, z_in, obj_done_in, ready_in,
        output ready_out, vert1_out, vert2_out, vert3_out, valid_tri_out,
               obj_done_out, count_out, drop_count_out
    );

    modport master (
        output valid_in, x_in, y_in, z_in, obj_done_in, ready_in,
        input  ready_out, vert1_out, vert2_out, vert3_out, valid_tri_out,
               obj_done_out, count_out, drop_count_out
    );
endinterface

// File: rtl/tri_assembler_fifo.sv
// rtl/tri_assembler_fifo.sv - groups vertices into triangles and buffers them in a fall-through FIFO
module tri_assembler_fifo #(
    parameter int COORD_W = 9,
    parameter int DEPTH   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    tri_assembler_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef logic [2:0][COORD_W-1:0] vert_t;

    logic [1:0]    idx;
    vert_t         h1, h2, cur;
    vert_t         mem_v1 [DEPTH];
    vert_t         mem_v2 [DEPTH];
    vert_t         mem_v3 [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pending_done;
    logic          obj_done_q;
    logic [7:0]    drop_count;

    logic ready, accept, push, valid_tri, pop, drop, done_fire;

    assign cur       = {bus.x_in, bus.y_in, bus.z_in};
    assign ready     = (count != FULL);
    assign accept    = bus.valid_in && ready;
    assign push      = accept && (idx == 2'd2);
    assign valid_tri = (count != '0);
    assign pop       = valid_tri && bus.ready_in;
    // End of object mid-triangle throws away the partial group unless it completes this cycle.
    assign drop      = bus.obj_done_in && (idx != 2'd0) && !push;
    assign done_fire = pending_done && (count == '0) && !push;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            idx          <= 2'd0;
            h1           <= '0;
            h2           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            pending_done <= 1'b0;
            obj_done_q   <= 1'b0;
            drop_count   <= 8'd0;
        end else begin
            if (drop)
                idx <= 2'd0;
            else if (accept)
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;

            if (accept && idx == 2'd0) h1 <= cur;
            if (accept && idx == 2'd1) h2 <= cur;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;

            obj_done_q   <= done_fire;
            pending_done <= bus.obj_done_in || (pending_done && !done_fire);
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_v1[wr_ptr] <= h1;
            mem_v2[wr_ptr] <= h2;
            mem_v3[wr_ptr] <= cur;
        end
    end

    assign bus.ready_out      = ready;
    assign bus.valid_tri_out  = valid_tri;
    assign bus.vert1_out      = valid_tri ? mem_v1[rd_ptr] : '0;
    assign bus.vert2_out      = valid_tri ? mem_v2[rd_ptr] : '0;
    assign bus.vert3_out      = valid_tri ? mem_v3[rd_ptr] : '0;
    assign bus.obj_done_out   = obj_done_q;
    assign bus.count_out      = count;
    assign bus.drop_count_out = drop_count;
endmodule

// File: tb/tb_tri_assembler_fifo.sv
// tb/tb_tri_assembler_fifo.sv - self-checking bench for tri_assembler_fifo
module tb_tri_assembler_fifo;
    localparam int W = 9;
    localparam int D = 16;

    typedef logic [3*W-1:0] vtx_t;
    typedef logic [9*W-1:0] tri_t;
    typedef struct {
        int              nv;
        logic [2:0][3*W-1:0] v;
        bit              coincide;
        int              exp_tris;
        int              exp_drop;
    } case_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tri_assembler_fifo_if #(.COORD_W(W), .DEPTH(D)) ifc ();
    tri_assembler_fifo #(.COORD_W(W), .DEPTH(D)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (ifc.slave)
    );

    int   passed = 0;
    int   total  = 0;
    tri_t got[$];
    vtx_t acc[$];
    int   cyc = 0, tri_cyc = 0, done_cyc = 0, done_n = 0;

    always @(negedge clk) begin
        cyc++;
        if (ifc.valid_tri_out && ifc.ready_in) begin
            got.push_back({ifc.vert1_out, ifc.vert2_out, ifc.vert3_out});
            tri_cyc = cyc;
        end
        if (ifc.obj_done_out) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vtx_t vx(input int x, input int y, input int z);
        logic [W-1:0] a, b, c;
        a = x[W-1:0];
        b = y[W-1:0];
        c = z[W-1:0];
        return {a, b, c};
    endfunction

    function automatic vtx_t mkv(input int j);
        return vx(j, j * 3, j * 7 + 1);
    endfunction

    function automatic case_t mk_case(input int nv, input vtx_t a, input vtx_t b, input vtx_t c,
                                      input bit co, input int et, input int ed);
        case_t r;
        r.nv = nv; r.v[0] = a; r.v[1] = b; r.v[2] = c;
        r.coincide = co; r.exp_tris = et; r.exp_drop = ed;
        return r;
    endfunction

    // Holds the vertex until the block accepts it, bounded.
    task automatic send_vertex(input vtx_t v, input bit done);
        int k;
        {ifc.x_in, ifc.y_in, ifc.z_in} = v;
        ifc.valid_in    = 1'b1;
        ifc.obj_done_in = done;
        for (k = 0; k < 500; k++) begin
            if (ifc.ready_out) break;
            step();
        end
        if (k == 500) begin
            total++;
            $display("FAIL send_timeout: got ready_out=0 for 500 cycles expected 1");
        end else begin
            acc.push_back(v);
        end
        step();
        ifc.valid_in    = 1'b0;
        ifc.obj_done_in = 1'b0;
    endtask

    // Triangle k must be accepted vertices 3k..3k+2 in order.
    task automatic compare_tris(input string name, input int gbase, input int abase, input int ntris);
        int mism;
        mism = 0;
        check({name, "_tri_count"}, got.size() - gbase, ntris);
        for (int k = 0; k < ntris && gbase + k < got.size(); k++)
            if (got[gbase + k] !== {acc[abase + 3*k], acc[abase + 3*k + 1], acc[abase + 3*k + 2]}) begin
                if (mism == 0)
                    $display("  first difference at triangle %0d: got %0h expected %0h", k, got[gbase + k],
                             {acc[abase + 3*k], acc[abase + 3*k + 1], acc[abase + 3*k + 2]});
                mism++;
            end
        check({name, "_tri_order"}, mism, 0);
    endtask

    initial begin
        case_t tbl[4];
        int    model_drop;
        int    gbase, abase, dbase, n, maxc;

        ifc.valid_in = 0; ifc.x_in = 0; ifc.y_in = 0; ifc.z_in = 0;
        ifc.obj_done_in = 0; ifc.ready_in = 0;
        model_drop = 0;

        tbl[0] = mk_case(3, vx(20, 20, 30), vx(20, 40, 30), vx(40, 20, 30), 1'b0, 1, 0);
        tbl[1] = mk_case(2, vx(1, 2, 3), vx(4, 5, 6), vx(0, 0, 0), 1'b0, 0, 1);
        tbl[2] = mk_case(3, vx(7, 8, 9), vx(10, 11, 12), vx(13, 14, 15), 1'b0, 1, 0);
        tbl[3] = mk_case(3, vx(100, 200, 300), vx(301, 302, 303), vx(511, 0, 511), 1'b1, 1, 0);

        step(); step();
        check("rst_ready",  ifc.ready_out, 1);
        check("rst_valid",  ifc.valid_tri_out, 0);
        check("rst_vert1",  ifc.vert1_out, 0);
        check("rst_done",   ifc.obj_done_out, 0);
        check("rst_count",  ifc.count_out, 0);
        check("rst_drop",   ifc.drop_count_out, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            gbase = got.size();
            dbase = done_n;
            ifc.ready_in = 1'b1;
            for (int j = 0; j < tbl[i].nv; j++)
                send_vertex(tbl[i].v[j], tbl[i].coincide && j == tbl[i].nv - 1);
            if (!tbl[i].coincide) begin
                ifc.obj_done_in = 1'b1;
                step();
                ifc.obj_done_in = 1'b0;
            end
            repeat (8) step();
            model_drop += tbl[i].exp_drop;
            check($sformatf("case%0d_tris", i), got.size() - gbase, tbl[i].exp_tris);
            if (tbl[i].exp_tris == 1 && got.size() > gbase) begin
                check($sformatf("case%0d_verts", i), got[gbase], {tbl[i].v[0], tbl[i].v[1], tbl[i].v[2]});
                check($sformatf("case%0d_done_lag", i), done_cyc - tri_cyc, 2);
            end
            check($sformatf("case%0d_done_pulses", i), done_n - dbase, 1);
            check($sformatf("case%0d_drop", i), ifc.drop_count_out, model_drop);
        end

        // Fill with the consumer stalled, then drain.
        gbase = got.size();
        abase = acc.size();
        ifc.ready_in = 1'b0;
        for (int j = 0; j < 3 * D; j++) send_vertex(mkv(j), 1'b0);
        {ifc.x_in, ifc.y_in, ifc.z_in} = mkv(3 * D);
        ifc.valid_in = 1'b1;
        step(); step();
        check("fill_count", ifc.count_out, D);
        check("fill_ready", ifc.ready_out, 0);
        check("fill_no_pop", got.size() - gbase, 0);
        ifc.ready_in = 1'b1;
        for (int j = 3 * D; j < 3 * D + 3; j++) send_vertex(mkv(j), 1'b0);
        repeat (40) step();
        compare_tris("fill", gbase, abase, D + 1);
        check("fill_drained", ifc.count_out, 0);

        // Random valid/ready traffic against the grouping model.
        gbase = got.size();
        abase = acc.size();
        n = 0;
        maxc = 0;
        for (int c = 0; c < 30000 && n < 999; c++) begin
            ifc.ready_in = ($urandom_range(0, 99) < 60);
            ifc.valid_in = ($urandom_range(0, 9) < 7);
            {ifc.x_in, ifc.y_in, ifc.z_in} = vtx_t'($urandom);
            if (ifc.valid_in && ifc.ready_out) begin
                acc.push_back({ifc.x_in, ifc.y_in, ifc.z_in});
                n++;
            end
            step();
            if (int'(ifc.count_out) > maxc) maxc = int'(ifc.count_out);
        end
        ifc.valid_in = 1'b0;
        ifc.ready_in = 1'b1;
        repeat (40) step();
        check("rand_vertices", n, 999);
        compare_tris("rand", gbase, abase, 333);
        check("rand_max_count", maxc <= D, 1);
        check("rand_count_end", ifc.count_out, 0);

        // Asynchronous reset with five triangles queued and one vertex held.
        ifc.ready_in = 1'b0;
        for (int j = 0; j < 16; j++) send_vertex(mkv(200 + j), 1'b0);
        check("pre_rst_count", ifc.count_out, 5);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ready", ifc.ready_out, 1);
        check("arst_valid", ifc.valid_tri_out, 0);
        check("arst_verts", {ifc.vert1_out, ifc.vert2_out, ifc.vert3_out}, 0);
        check("arst_count", ifc.count_out, 0);
        check("arst_done",  ifc.obj_done_out, 0);
        check("arst_drop",  ifc.drop_count_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        gbase = got.size();
        abase = acc.size();
        ifc.ready_in = 1'b1;
        for (int j = 0; j < 3; j++) send_vertex(mkv(300 + j), 1'b0);
        repeat (5) step();
        compare_tris("post_rst", gbase, abase, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
